// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and width helpers for param_fifo and fifo_ram
package fifo_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_FIFO_DEPTH = 16;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic int addr_w(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction
   function automatic int cnt_w(input int depth);
      return addr_w(depth) + 1;
   endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DW storage, one synchronous write port, one asynchronous read port
//   clk, we, waddr, wdata : write port (written on rising edge when we)
//   raddr, rdata          : combinational read port
module fifo_ram #(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with occupancy count, programmable thresholds and error pulses
//   clk, rst (async, active-high)
//   we/data_in write side; re/data_out read side
//   empty, full, almost_full, almost_empty, count: decoded from registered occupancy
//   overflow/underflow: single-cycle pulse after a rejected write/read
//   FIFO_FWFT_EN: first-word-fall-through (data_out = head word, valid while !empty);
//   undefined: data_out registered, updated the cycle after an accepted read
module param_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int AF_LEVEL   = FIFO_DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          we,
   input  logic                          re,
   input  logic [DATA_WIDTH-1:0]         data_in,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          empty,
   output logic                          full,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [cnt_w(FIFO_DEPTH)-1:0]  count,
   output logic                          overflow,
   output logic                          underflow
);
   localparam int AW = addr_w(FIFO_DEPTH);
   localparam int CW = cnt_w(FIFO_DEPTH);
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] rdata;
   logic wr_ok, re_ok;
   assign empty        = count == '0;
   assign full         = count == CW'(FIFO_DEPTH);
   assign almost_full  = count >= CW'(AF_LEVEL);
   assign almost_empty = count <= CW'(AE_LEVEL);
   // a read freeing a slot lets a write into a full FIFO on the same edge
   assign re_ok = re & ~empty;
   assign wr_ok = we & (~full | re_ok);
   fifo_ram #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (rdata)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (re_ok) rd_ptr <= rd_ptr + AW'(1);
         if (wr_ok != re_ok) count <= wr_ok ? count + CW'(1) : count - CW'(1);
         overflow  <= we & ~wr_ok;
         underflow <= re & ~re_ok;
      end
`ifdef FIFO_FWFT_EN
   assign data_out = rdata;
`else
   always_ff @(posedge clk or posedge rst)
      if (rst) data_out <= '0;
      else if (re_ok) data_out <= rdata;
`endif
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: queue-model comparison every cycle plus directed literal checks for param_fifo
module tb_param_fifo;
   localparam int DW = 8, DEPTH = 16, AF = 14, AE = 2;
   logic clk = 1'b0, rst = 1'b1, we = 1'b0, re = 1'b0;
   logic [DW-1:0] data_in = '0, data_out;
   logic empty, full, almost_full, almost_empty, overflow, underflow;
   logic [4:0] count;
   int total = 0, bad = 0;
   param_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk(clk), .rst(rst), .we(we), .re(re), .data_in(data_in), .data_out(data_out),
      .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
      end
   endtask
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout = '0;
   logic m_ov = 1'b0, m_un = 1'b0;
   always @(posedge clk or posedge rst) begin
      bit rok, wok;
      if (rst) begin
         q.delete();
         m_dout = '0;
         m_ov = 1'b0;
         m_un = 1'b0;
      end else begin
         rok = re && q.size() > 0;
         wok = we && (q.size() < DEPTH || rok);
         if (rok) m_dout = q.pop_front();
         if (wok) q.push_back(data_in);
         m_ov = we && !wok;
         m_un = re && !rok;
      end
   end
   always @(negedge clk) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("underflow", 32'(underflow), 32'(m_un));
`ifdef FIFO_FWFT_EN
      if (q.size() > 0) chk("data_out", 32'(data_out), 32'(q[0]));
`else
      chk("data_out", 32'(data_out), 32'(m_dout));
`endif
   end
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
      we = w;
      re = r;
      data_in = d;
      @(posedge clk);
      #1;
      we = 1'b0;
      re = 1'b0;
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_ae", 32'(almost_empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_af", 32'(almost_full), 0);
`ifndef FIFO_FWFT_EN
      chk("rst_dout", 32'(data_out), 0);
`endif
      for (int i = 0; i < 16; i++) begin
         step(1, 0, DW'(i));
         chk("fill_count", 32'(count), 32'(i + 1));
         chk("fill_af", 32'(almost_full), 32'(i + 1 >= 14));
      end
      chk("fill_full", 32'(full), 1);
      for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
         chk("drain_head", 32'(data_out), 32'(i));
         step(0, 1, 0);
`else
         step(0, 1, 0);
         chk("drain_dout", 32'(data_out), 32'(i));
`endif
      end
      chk("drain_empty", 32'(empty), 1);
      for (int i = 0; i < 16; i++) step(1, 0, DW'(8'h10 + i));
      step(1, 0, 8'hAA);
      chk("ovf_pulse", 32'(overflow), 1);
      chk("ovf_count", 32'(count), 16);
      step(0, 0, 0);
      chk("ovf_clear", 32'(overflow), 0);
      for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
         chk("ovf_head", 32'(data_out), 32'(8'h10 + i));
         step(0, 1, 0);
`else
         step(0, 1, 0);
         chk("ovf_dout", 32'(data_out), 32'(8'h10 + i));
`endif
      end
      step(1, 1, 8'h55);
      chk("unf_pulse", 32'(underflow), 1);
      chk("unf_count", 32'(count), 1);
`ifdef FIFO_FWFT_EN
      chk("unf_head", 32'(data_out), 32'h55);
      step(0, 1, 0);
`else
      step(0, 1, 0);
      chk("unf_dout", 32'(data_out), 32'h55);
`endif
      chk("unf_clear", 32'(underflow), 0);
      for (int i = 0; i < 16; i++) step(1, 0, DW'(i));
      for (int k = 0; k < 20; k++) begin
`ifdef FIFO_FWFT_EN
         chk("both_head", 32'(data_out), 32'(k < 16 ? k : 8'h80 + k - 16));
         step(1, 1, DW'(8'h80 + k));
`else
         step(1, 1, DW'(8'h80 + k));
         chk("both_dout", 32'(data_out), 32'(k < 16 ? k : 8'h80 + k - 16));
`endif
         chk("both_count", 32'(count), 16);
         chk("both_ovf", 32'(overflow), 0);
      end
      for (int i = 0; i < 8; i++) step(0, 1, 0);
      we = 1'b1;
      data_in = 8'h77;
      rst = 1'b1;
      #1;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_empty", 32'(empty), 1);
      chk("mid_rst_full", 32'(full), 0);
      chk("mid_rst_ae", 32'(almost_empty), 1);
`ifndef FIFO_FWFT_EN
      chk("mid_rst_dout", 32'(data_out), 0);
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      we = 1'b0;
      chk("post_rst_count", 32'(count), 0);
`ifdef FIFO_FWFT_EN
      step(1, 0, 8'h3C);
      chk("fwft_empty", 32'(empty), 0);
      chk("fwft_head", 32'(data_out), 32'h3C);
      step(0, 1, 0);
      chk("fwft_pop_empty", 32'(empty), 1);
`else
      step(1, 0, 8'h3C);
      chk("reg_hold", 32'(data_out), 0);
      step(0, 1, 0);
      chk("reg_dout", 32'(data_out), 32'h3C);
      chk("reg_pop_empty", 32'(empty), 1);
`endif
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parametrised synchronous FIFO, the successor to the basic lab FIFO. Adds true full/empty based on an occupancy counter, programmable almost-full/almost-empty thresholds, an occupancy output, and overflow/underflow error pulses. Defined simultaneous read/write behaviour at all boundaries. Sits between a producer and a consumer in one clock domain; used as the standard buffer in later lab designs.

Parameters:
DATA_WIDTH, 8, word width in bits (>=1)
FIFO_DEPTH, 16, number of storage words; power of two, >=2
AF_LEVEL, FIFO_DEPTH-2, almost_full asserted when count >= AF_LEVEL (1..FIFO_DEPTH)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..FIFO_DEPTH-1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
we  in  1  write request
re  in  1  read request
data_in  in  DATA_WIDTH  write data
data_out  out  DATA_WIDTH  read data
empty  out  1  count == 0
full  out  1  count == FIFO_DEPTH
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  current occupancy, 0..FIFO_DEPTH (ADDR_W = clog2(FIFO_DEPTH))
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (async assert, sync-safe deassert not required): write_ptr=0, read_ptr=0, count=0, data_out=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_empty=1, almost_full=0. Memory contents not reset.
- Flags are combinational decodes of registered count; no extra latency beyond count.
- Accept rules evaluated on the same edge: wr_ok = we & (~full | re_ok); re_ok = re & ~empty.
- Full + we + re: both accepted, count unchanged, write lands in freed slot.
- Empty + we + re: read rejected (underflow=1), write accepted, count 0->1.
- we & ~wr_ok -> overflow=1 next cycle, pointers/memory/count untouched. re & ~re_ok -> underflow=1 next cycle. Pulses are single-cycle, not sticky.
- count: +1 on wr_ok only, -1 on re_ok only, unchanged on both/neither.
- Pointers ADDR_W bits, wrap naturally from FIFO_DEPTH-1 to 0.
- Read latency (default mode): data_out registered; word at read_ptr appears on data_out the cycle after re_ok. data_out holds its value when no read is accepted.
- Write-to-read: a word written on edge N is readable (re accepted) from edge N+1.
- rst mid-operation: all pointers/count cleared immediately; in-flight data discarded; outputs return to reset values within the same cycle.

Optional Feature:
FIFO_FWFT_EN. When defined: first-word-fall-through mode; data_out is the combinational read of mem[read_ptr] and is valid whenever empty=0; re_ok pops the head and data_out shows the next word in the same cycle after the edge; data_out value undefined while empty. When undefined: registered-output mode as described above. Flags, count and error pulses identical in both modes.

Decomposition:
- Package fifo_pkg: clog2 constant function, ADDR_W/CNT_W derivation helpers, default DATA_WIDTH/FIFO_DEPTH constants.
- One sub-module: fifo_ram, simple dual-port memory (1 write port, 1 async read port, FIFO_DEPTH x DATA_WIDTH); control, counter, flags and output register stay in param_fifo.

Test Plan:
- Reset: assert rst 3 cycles mid-traffic -> count=0, empty=1, full=0, almost_empty=1, data_out=0 immediately on assert.
- Fill/drain: write 16 words 0x00..0x0F, then read 16 -> full=1 at count=16, almost_full from count=14, data_out sequence 0x00..0x0F (one cycle after each re), empty=1 at end.
- Overflow: full FIFO, we=1 re=0 with data_in=0xAA -> overflow=1 one cycle, count stays 16, 0xAA never read out.
- Underflow: empty FIFO, re=1 we=1 data_in=0x55 -> underflow=1, count=1, next read returns 0x55.
- Full simultaneous: count=16, we=re=1 for 20 cycles -> count stays 16, no overflow, output order preserved across pointer wrap.
- FWFT build (FIFO_FWFT_EN): write 0x3C to empty FIFO -> next cycle empty=0 and data_out=0x3C before any re; re pops, empty=1.
